// File: rtl/hazard_sched_pkg.sv
// hazard_sched_pkg -- shared definitions for the hazard sequencer.
//   RFIDX_WIDTH : register index width used across the datapath.
//   FWD_*       : ALU operand source selects (regfile / W result / M aluout).
//   state_t     : memory-wait FSM states.
package hazard_sched_pkg;

  localparam int unsigned RFIDX_WIDTH = 5;

  localparam logic [1:0] FWD_RF = 2'b00;
  localparam logic [1:0] FWD_W  = 2'b01;
  localparam logic [1:0] FWD_M  = 2'b10;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } state_t;

endpackage

// File: rtl/hazard_sched_fwd_sel.sv
// hazard_sched_fwd_sel -- forwarding comparator for one ALU source operand.
//   rs             : E-stage source register index
//   validM/rwM/rdM : M-slot valid, regwrite, destination
//   validW/rwW/rdW : W-slot valid, regwrite, destination
//   sel            : FWD_M if M produces rs, else FWD_W if W does, else FWD_RF.
//                    x0 is never forwarded.
module hazard_sched_fwd_sel
  import hazard_sched_pkg::*;
#(
  parameter int unsigned RFIDX_W = RFIDX_WIDTH
) (
  input  logic [RFIDX_W-1:0] rs,
  input  logic               validM,
  input  logic               rwM,
  input  logic [RFIDX_W-1:0] rdM,
  input  logic               validW,
  input  logic               rwW,
  input  logic [RFIDX_W-1:0] rdW,
  output logic [1:0]         sel
);

  logic hitM;
  logic hitW;

  always_comb begin
    hitM = validM & rwM & (rdM != '0) & (rdM == rs);
    hitW = validW & rwW & (rdW != '0) & (rdW == rs);
    sel  = FWD_RF;
    if (hitM) begin
      sel = FWD_M;
    end else if (hitW) begin
      sel = FWD_W;
    end
  end

endmodule

// File: rtl/hazard_sched.sv
// hazard_sched -- stall/flush/forward sequencer for the 5-stage xgriscv pipeline.
// Keeps a shadow scoreboard of the E/M/W slots and derives pipeline controls.
//   clk, reset                     : clock, asynchronous active-high reset
//   rs1D, rs2D, rdD                : decode-stage register indices
//   regwriteD, memtoregD, memwriteD: decode-stage instruction class
//   pcsrcE                         : taken branch/jump resolved in E
//   memreadyM                      : data memory finishes the M access this cycle
//   stallF/D/E/M                   : hold PC, IF/ID, ID/EX, EX/MEM
//   flushD/E/W                     : clear IF/ID, ID/EX, MEM/WB
//   fwdaE, fwdbE                   : ALU srcA/srcB forwarding selects
// Optional (macro HAZARD_SCHED_PERF_EN): stall_cnt, flush_cnt, fwd_cnt
// performance counters, PERF_W bits, wrapping, cleared on reset.
module hazard_sched
  import hazard_sched_pkg::*;
#(
  parameter int unsigned RFIDX_W = RFIDX_WIDTH,
  parameter int unsigned PERF_W  = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [RFIDX_W-1:0] rs1D,
  input  logic [RFIDX_W-1:0] rs2D,
  input  logic [RFIDX_W-1:0] rdD,
  input  logic               regwriteD,
  input  logic               memtoregD,
  input  logic               memwriteD,
  input  logic               pcsrcE,
  input  logic               memreadyM,
  output logic               stallF,
  output logic               stallD,
  output logic               stallE,
  output logic               stallM,
  output logic               flushD,
  output logic               flushE,
  output logic               flushW,
  output logic [1:0]         fwdaE,
  output logic [1:0]         fwdbE
`ifdef HAZARD_SCHED_PERF_EN
  ,
  output logic [PERF_W-1:0]  stall_cnt,
  output logic [PERF_W-1:0]  flush_cnt,
  output logic [PERF_W-1:0]  fwd_cnt
`endif
);

  // Scoreboard slots. Only fields consumed downstream are kept: M needs
  // mreq for the memory stall, W only needs what forwarding compares.
  logic               validE, validM, validW;
  logic [RFIDX_W-1:0] rdE, rdM, rdW;
  logic [RFIDX_W-1:0] rs1E, rs2E;
  logic               rwE, rwM, rwW;
  logic               mtrE;
  logic               mreqE, mreqM;

  state_t state, stateNext;

  logic memStall;
  logic freeze;
  logic branch;
  logic loadUse;
  logic [1:0] selA, selB;

  assign memStall = validM & mreqM & ~memreadyM;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= stateNext;
    end
  end

  // In WAIT the M slot is frozen holding a valid memory request, so
  // ~memreadyM there is the same condition as memStall.
  always_comb begin
    stateNext = state;
    freeze    = 1'b0;
    unique case (state)
      S_IDLE: begin
        freeze = memStall;
        if (memStall) stateNext = S_WAIT;
      end
      S_WAIT: begin
        freeze = ~memreadyM;
        if (memreadyM) stateNext = S_IDLE;
      end
      default: ;
    endcase
  end

  always_comb begin
    branch  = pcsrcE & ~freeze;
    loadUse = ~freeze & ~pcsrcE & validE & mtrE & (rdE != '0) &
              ((rdE == rs1D) | (rdE == rs2D));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      validE <= 1'b0;
      validM <= 1'b0;
      validW <= 1'b0;
      rdE    <= '0;
      rdM    <= '0;
      rdW    <= '0;
      rs1E   <= '0;
      rs2E   <= '0;
      rwE    <= 1'b0;
      rwM    <= 1'b0;
      rwW    <= 1'b0;
      mtrE   <= 1'b0;
      mreqE  <= 1'b0;
      mreqM  <= 1'b0;
    end else if (freeze) begin
      validW <= 1'b0;
    end else begin
      validW <= validM;
      rdW    <= rdM;
      rwW    <= rwM;
      validM <= validE;
      rdM    <= rdE;
      rwM    <= rwE;
      mreqM  <= mreqE;
      if (branch | loadUse) begin
        validE <= 1'b0;
      end else begin
        validE <= 1'b1;
        rdE    <= rdD;
        rs1E   <= rs1D;
        rs2E   <= rs2D;
        rwE    <= regwriteD;
        mtrE   <= memtoregD;
        mreqE  <= memwriteD | memtoregD;
      end
    end
  end

  hazard_sched_fwd_sel #(.RFIDX_W(RFIDX_W)) uFwdA (
    .rs(rs1E), .validM(validM), .rwM(rwM), .rdM(rdM),
    .validW(validW), .rwW(rwW), .rdW(rdW), .sel(selA)
  );

  hazard_sched_fwd_sel #(.RFIDX_W(RFIDX_W)) uFwdB (
    .rs(rs2E), .validM(validM), .rwM(rwM), .rdM(rdM),
    .validW(validW), .rwW(rwW), .rdW(rdW), .sel(selB)
  );

  // Outputs forced low while reset is held so a stray pcsrcE cannot leak.
  always_comb begin
    stallF = 1'b0;
    stallD = 1'b0;
    stallE = 1'b0;
    stallM = 1'b0;
    flushD = 1'b0;
    flushE = 1'b0;
    flushW = 1'b0;
    fwdaE  = FWD_RF;
    fwdbE  = FWD_RF;
    if (!reset) begin
      stallF = freeze | loadUse;
      stallD = freeze | loadUse;
      stallE = freeze;
      stallM = freeze;
      flushD = branch;
      flushE = branch | loadUse;
      flushW = freeze;
      fwdaE  = selA;
      fwdbE  = selB;
    end
  end

`ifdef HAZARD_SCHED_PERF_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
      fwd_cnt   <= '0;
    end else begin
      if (stallF) stall_cnt <= stall_cnt + PERF_W'(1);
      if (flushE) flush_cnt <= flush_cnt + PERF_W'(1);
      if ((fwdaE != FWD_RF) || (fwdbE != FWD_RF)) fwd_cnt <= fwd_cnt + PERF_W'(1);
    end
  end
`endif

endmodule

// File: doc/hazard_sched.md
Name: hazard_sched

Overview:
- Pipeline sequencer for the 5-stage xgriscv datapath.
- Keeps a shadow scoreboard of the E/M/W slots: rd, regwrite, memtoreg, memory request, and E-stage rs1/rs2.
- From that state it generates stall, flush and bubble controls plus ALU-operand forwarding selects.
- A small FSM freezes the pipeline while a multi-cycle data-memory access completes.

Parameters:
- RFIDX_W, 5, register index width.
- PERF_W, 32, width of optional performance counters.

Ports:
- clk  in  1  clock.
- reset  in  1  reset; one clock; asynchronous, active-high.
- rs1D  in  RFIDX_W  decode-stage source 1.
- rs2D  in  RFIDX_W  decode-stage source 2.
- rdD  in  RFIDX_W  decode-stage destination.
- regwriteD  in  1  decode instruction writes rd.
- memtoregD  in  1  decode instruction is a load.
- memwriteD  in  1  decode instruction is a store.
- pcsrcE  in  1  taken branch/jump resolved in E.
- memreadyM  in  1  data memory completes the M-stage access this cycle.
- stallF  out  1  hold PC register.
- stallD  out  1  hold IF/ID registers.
- stallE  out  1  hold ID/EX registers.
- stallM  out  1  hold EX/MEM registers.
- flushD  out  1  clear IF/ID.
- flushE  out  1  clear ID/EX (bubble).
- flushW  out  1  clear MEM/WB (bubble).
- fwdaE  out  2  srcA select: 00 regfile, 01 W result, 10 M aluout.
- fwdbE  out  2  srcB select, same encoding.

Behaviour:
- Slots E, M, W each hold: valid, rd, rw, mtr, mreq (= memwriteD|memtoregD); slot E also holds rs1, rs2.
- Reset: all slots invalid, FSM=IDLE, all outputs 0, fwd = 00. Reset asserted mid-WAIT returns the FSM to IDLE immediately.
- memstall = slot M valid & mreqM & !memreadyM.
- Priority order: memstall > pcsrcE > load-use.
- FSM states:
  - IDLE: on memstall go to WAIT.
  - WAIT: stay while !memreadyM; go to IDLE on the memreadyM cycle.
  - memreadyM=1 in the first M cycle means no stall, and the FSM stays IDLE.
- While memstall: stallF=stallD=stallE=stallM=1, flushW=1, flushD=flushE=0.
  - Slots E and M hold; slot W loads invalid.
  - A pcsrcE present during the stall is deferred: it acts on the release cycle, because E is frozen.
- Branch (pcsrcE, no memstall): flushD=flushE=1, no stall. Slot E loads invalid; slot M takes old E.
- Load-use: slot E valid & mtrE & rdE!=0 & (rdE==rs1D | rdE==rs2D), with no branch and no memstall.
  - Response: stallF=stallD=1, flushE=1, for exactly one cycle; slot E loads invalid.
- Normal advance: D→E→M→W each cycle.
- Forwarding (per source, E-stage rs vs rd):
  - 10 if slot M valid & rw & rd!=0 & rd==rs.
  - else 01 if slot W valid & rw & rd!=0 & rd==rs.
  - else 00.
  - M has priority over W.
  - x0 is never forwarded.
  - Forward selects are driven purely from registered slot state.
- Load in M with rd==rsE cannot occur (guaranteed by the load-use stall); no special case is needed.

Optional Feature:
- Macro: HAZARD_SCHED_PERF_EN.
- When defined, adds output ports stall_cnt, flush_cnt, fwd_cnt (each PERF_W):
  - stall_cnt: +1 per cycle with stallF=1.
  - flush_cnt: +1 per cycle with flushE=1.
  - fwd_cnt: +1 per cycle with fwdaE or fwdbE nonzero.
- Counters wrap modulo 2^PERF_W and clear on reset.
- When undefined: ports and counters are absent, and core behaviour is identical.

Decomposition:
- Shared package/defines:
  - FWD_RF=2'b00, FWD_W=2'b01, FWD_M=2'b10.
  - FSM encodings S_IDLE/S_WAIT.
  - RFIDX_WIDTH reused from the existing defines.
- One natural sub-module: fwd_sel, the combinational forwarding comparator, instantiated once per source operand.

Test Plan:
- ALU RAW: add x5 in M, E-instr rs1=5 → fwdaE=10. Next cycle x5 in W, new E rs2=5 → fwdbE=01. rd=x0 in M with rs1=0 → fwdaE=00.
- Load-use: lw x6 in E, D-instr rs2=6 → stallF=stallD=flushE=1 for 1 cycle. Following cycle the load is in M, and fwdbE=01 once the load is in W.
- Branch: pcsrcE=1 → flushD=flushE=1, stalls 0. A simultaneous load-use condition is suppressed, with no stall.
- Memory wait: sw in M, memreadyM low 3 cycles → FSM WAIT; stallF..stallM=1 and flushW=1 for 3 cycles. memreadyM=1 on the 4th → FSM IDLE, all stalls 0.
- Deferred branch: pcsrcE=1 during memstall → flushD/flushE stay 0 until memreadyM=1, then assert on that release cycle.
- Reset asserted while in WAIT → outputs 0 asynchronously, FSM IDLE. With HAZARD_SCHED_PERF_EN, counters read 0 after reset, and stall_cnt=3 after the memory-wait scenario.
